axi_stream_strip_header: RTL and testbench

- Downstream counterpart of the header-insertion stage.
- Removes a per-packet, configurable number of leading bytes (0..DATA_BYTE_WD-1) from an AXI-Stream packet.
- Re-aligns the remaining payload to full MSB-first beats and presents the stripped bytes on a sideband header port.
- Sits after packet reception, before payload consumers; sustains one beat per cycle in steady state.

---
 rtl/axi_stream_pkg.sv | 6 +
 rtl/keep_popcount.sv | 15 +
 rtl/axi_stream_strip_header.sv | 179 +++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared types and constants for the AXI-Stream header insert/strip stages.
package axi_stream_pkg;
    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_e;
    localparam int BYTE_W     = 8;
    localparam int BYTE_SHIFT = 3;  // log2(BYTE_W): byte count -> bit count
endpackage

// File: rtl/keep_popcount.sv
// Counts the set lanes of a keep vector; contiguity is not assumed.
module keep_popcount #(
    parameter int DATA_BYTE_WD = 4,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_BYTE_WD-1:0] keep_i,
    output logic [CNT_WD-1:0]       cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            cnt_o = cnt_o + CNT_WD'(keep_i[i]);
        end
    end
endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips s leading bytes from each packet, re-packs the payload MSB-first and
// reports the stripped bytes on a one-cycle header sideband.
module axi_stream_strip_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    output logic                    err_short
);
    localparam int CW    = BYTE_CNT_WD + 1;
    localparam int SH_WD = BYTE_CNT_WD + 4;
    localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);

    function automatic logic [DATA_BYTE_WD-1:0] ones(input logic [CW-1:0] k);
        return ~({DATA_BYTE_WD{1'b1}} >> k);
    endfunction

    state_e                  state_q, state_d;
    logic [CW-1:0]           s_q, s_d, left_q, left_d;
    logic [DATA_WD-1:0]      res_q, res_d, dout_q, dout_d, dhdr_q, dhdr_d;
    logic [DATA_BYTE_WD-1:0] kout_q, kout_d, khdr_q, khdr_d;
    logic                    vout_q, vout_d, lout_q, lout_d;
    logic                    vhdr_q, vhdr_d, err_q, err_d;

    logic [CW-1:0]    n;
    logic [CW:0]      total;
    logic [SH_WD-1:0] sh_s, sh_r;
    logic             out_free, in_hs;

    keep_popcount #(.DATA_BYTE_WD(DATA_BYTE_WD), .CNT_WD(CW)) u_pop (
        .keep_i (keep_in),
        .cnt_o  (n)
    );

    // Shift amounts widened so that (W-s)*8 == DATA_WD for s=0 does not wrap.
    assign sh_s     = SH_WD'(s_q) << BYTE_SHIFT;
    assign sh_r     = SH_WD'(W_C - s_q) << BYTE_SHIFT;
    assign total    = (CW+1)'(W_C - s_q) + (CW+1)'(n);
    assign out_free = !vout_q || ready_out;
    assign in_hs    = valid_in && ready_in;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        left_d      = left_q;
        res_d       = res_q;
        vout_d      = vout_q && !ready_out;
        dout_d      = dout_q;
        kout_d      = kout_q;
        lout_d      = lout_q;
        vhdr_d      = 1'b0;
        dhdr_d      = dhdr_q;
        khdr_d      = khdr_q;
        err_d       = 1'b0;
        ready_in    = 1'b0;
        ready_strip = 1'b0;
        case (state_q)
            IDLE: begin
                ready_strip = 1'b1;
                if (valid_strip) begin
                    s_d     = (byte_strip_cnt >= W_C) ? W_C - 1'b1 : byte_strip_cnt;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                ready_in = out_free;
                if (in_hs) begin
                    vhdr_d = 1'b1;
                    dhdr_d = data_in & ~({DATA_WD{1'b1}} >> sh_s);
                    khdr_d = ones(s_q);
                    res_d  = data_in << sh_s;
                    if (!last_in) begin
                        state_d = BODY;
                    end else if (n <= s_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        vout_d  = 1'b1;
                        dout_d  = data_in << sh_s;
                        kout_d  = ones(n - s_q);
                        lout_d  = 1'b1;
                        state_d = FLUSH;
                    end
                end
            end
            BODY: begin
                ready_in = out_free;
                if (in_hs) begin
                    vout_d = 1'b1;
                    dout_d = res_q | (data_in >> sh_r);
                    res_d  = data_in << sh_s;
                    kout_d = '1;
                    lout_d = 1'b0;
                    if (last_in) begin
                        state_d = FLUSH;
                        if (total <= (CW+1)'(DATA_BYTE_WD)) begin
                            kout_d = ones(total[CW-1:0]);
                            lout_d = 1'b1;
                        end else begin
                            left_d = n - s_q;
                        end
                    end
                end
            end
            FLUSH: begin
                // Holds until the packet's last beat is taken; loads the
                // leftover beat first if the last input beat overflowed.
                if (vout_q && lout_q) begin
                    if (ready_out) state_d = IDLE;
                end else if (out_free) begin
                    vout_d = 1'b1;
                    dout_d = res_q;
                    kout_d = ones(left_q);
                    lout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            left_q  <= '0;
            res_q   <= '0;
            vout_q  <= 1'b0;
            dout_q  <= '0;
            kout_q  <= '0;
            lout_q  <= 1'b0;
            vhdr_q  <= 1'b0;
            dhdr_q  <= '0;
            khdr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            left_q  <= left_d;
            res_q   <= res_d;
            vout_q  <= vout_d;
            dout_q  <= dout_d;
            kout_q  <= kout_d;
            lout_q  <= lout_d;
            vhdr_q  <= vhdr_d;
            dhdr_q  <= dhdr_d;
            khdr_q  <= khdr_d;
            err_q   <= err_d;
        end
    end

    assign valid_out = vout_q;
    assign data_out  = dout_q;
    assign keep_out  = kout_q;
    assign last_out  = lout_q;
    assign valid_hdr = vhdr_q;
    assign data_hdr  = dhdr_q;
    assign keep_hdr  = khdr_q;
    assign err_short = err_q;
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Randomized bench for axi_stream_strip_header against a byte-queue packet model.
module tb_axi_stream_strip_header;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, ready_out, last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_strip, ready_strip;
    logic [2:0]  byte_strip_cnt;
    logic        valid_hdr, err_short;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;

    always #5 clk = ~clk;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .keep_in(keep_in), .last_in(last_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .keep_out(keep_out), .last_out(last_out),
        .valid_strip(valid_strip), .ready_strip(ready_strip),
        .byte_strip_cnt(byte_strip_cnt),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr),
        .err_short(err_short)
    );

    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    beat_t       exp_q[$];
    beat_t       hdr_q[$];
    beat_t       mb, mh;
    int          exp_err = 0;
    int          nchk = 0, npass = 0;
    bit          mon_en = 0;
    bit          stall_pend = 0;
    logic [37:0] stall_val;
    logic [31:0] pw [0:3];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    always begin
        @(posedge clk); #1;
        if (mon_en) ready_out = ($urandom_range(0, 1) == 1);
    end

    always @(negedge clk) if (mon_en) begin
        if (stall_pend)
            chk("stall_hold", 64'({valid_out, last_out, keep_out, data_out}), 64'(stall_val));
        if (valid_out && ready_out) begin
            if (exp_q.size() == 0) chk("extra_beat", 64'(valid_out), 64'(0));
            else begin
                mb = exp_q.pop_front();
                chk("keep_out", 64'(keep_out), 64'(mb.k));
                chk("last_out", 64'(last_out), 64'(mb.l));
                chk("data_out", 64'(data_out & kmask(mb.k)), 64'(mb.d & kmask(mb.k)));
            end
        end
        stall_pend = valid_out && !ready_out;
        stall_val  = {valid_out, last_out, keep_out, data_out};
        if (valid_hdr) begin
            if (hdr_q.size() == 0) chk("extra_hdr", 64'(valid_hdr), 64'(0));
            else begin
                mh = hdr_q.pop_front();
                chk("keep_hdr", 64'(keep_hdr), 64'(mh.k));
                chk("data_hdr", 64'(data_hdr), 64'(mh.d));
            end
        end
        if (err_short) begin
            chk("err_short", 64'(err_short), 64'(exp_err > 0 ? 1 : 0));
            if (exp_err > 0) exp_err--;
        end
    end

    task automatic do_cfg(input int c);
        bit ok = 0;
        valid_strip = 1'b1;
        byte_strip_cnt = 3'(c);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); ok = ready_strip;
            @(posedge clk); #1;
        end
        valid_strip = 1'b0;
        if (!ok) chk("cfg_timeout", 64'(ready_strip), 64'(1));
    endtask

    task automatic do_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit ok = 0;
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); ok = ready_in;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        if (!ok) chk("beat_timeout", 64'(ready_in), 64'(1));
    endtask

    // Model: strip the first s bytes of the byte stream, re-chunk the rest into W-byte beats.
    task automatic send_pkt(input int c, input int len);
        int s  = (c > W - 1) ? W - 1 : c;
        int nb = (len + W - 1) / W;
        int p;
        logic [7:0] b [0:15];
        logic [3:0] kk;
        beat_t h;
        for (int i = 0; i < len; i++) b[i] = pw[i/4][31-8*(i%4) -: 8];
        h.d = '0; h.k = '0; h.l = 1'b0;
        for (int i = 0; i < s; i++) begin
            h.d[31-8*i -: 8] = pw[0][31-8*i -: 8];
            h.k[3-i] = 1'b1;
        end
        hdr_q.push_back(h);
        if (len <= s) exp_err++;
        else begin
            p = s;
            while (p < len) begin
                beat_t e;
                e.d = '0; e.k = '0;
                for (int j = 0; j < W && p < len; j++) begin
                    e.d[31-8*j -: 8] = b[p];
                    e.k[3-j] = 1'b1;
                    p++;
                end
                e.l = (p == len);
                exp_q.push_back(e);
            end
        end
        do_cfg(c);
        for (int bi = 0; bi < nb; bi++) begin
            kk = 4'hF << (W - ((bi == nb - 1) ? len - W*bi : W));
            do_beat(pw[bi], kk, bi == nb - 1);
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk); #1;
            done = (exp_q.size() == 0) && (hdr_q.size() == 0) && (exp_err == 0) && ready_strip;
        end
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b0; valid_strip = 1'b0; byte_strip_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(valid_out), 64'(0));
        chk("rst_ready_strip", 64'(ready_strip), 64'(1));
        chk("rst_ready_in", 64'(ready_in), 64'(0));
        chk("rst_valid_hdr", 64'(valid_hdr), 64'(0));
        chk("rst_err_short", 64'(err_short), 64'(0));
        rst = 1'b0;
        mon_en = 1;

        pw[0] = 32'hA0A1A2A3; pw[1] = 32'hB0B1B2B3; pw[2] = 32'hC0C15A5A; pw[3] = '0;
        send_pkt(1, 10);
        send_pkt(3, 10);
        wait_drain();
        pw[0] = 32'hD0D15A5A;
        send_pkt(2, 2);
        chk("short_no_vout", 64'(valid_out), 64'(0));
        @(posedge clk); #1;
        chk("short_rdy_strip", 64'(ready_strip), 64'(1));
        pw[0] = 32'hE0E1E2E3; pw[1] = 32'hF05A5A5A;
        send_pkt(0, 5);
        pw[0] = 32'h11223344; pw[1] = 32'h55667788;
        send_pkt(6, 7);

        for (int k = 0; k < 100; k++) begin
            for (int w = 0; w < 4; w++) pw[w] = $urandom;
            send_pkt($urandom_range(0, 7), $urandom_range(1, 14));
        end
        wait_drain();

        mon_en = 0;
        ready_out = 1'b0;
        for (int w = 0; w < 4; w++) pw[w] = $urandom;
        do_cfg(1);
        do_beat(pw[0], 4'hF, 1'b0);
        do_beat(pw[1], 4'hF, 1'b0);
        @(negedge clk);
        chk("pre_rst_vout", 64'(valid_out), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_vout", 64'(valid_out), 64'(0));
        chk("mid_rst_last", 64'(last_out), 64'(0));
        chk("mid_rst_dout", 64'(data_out), 64'(0));
        chk("mid_rst_kout", 64'(keep_out), 64'(0));
        chk("mid_rst_hdr", 64'({valid_hdr, keep_hdr, data_hdr}), 64'(0));
        chk("mid_rst_err", 64'(err_short), 64'(0));
        chk("mid_rst_rdy_in", 64'(ready_in), 64'(0));
        chk("mid_rst_rdy_strip", 64'(ready_strip), 64'(1));
        stall_pend = 0;
        mon_en = 1;
        pw[0] = 32'h01020304; pw[1] = 32'h05060708;
        send_pkt(1, 7);
        wait_drain();

        chk("left_beats", 64'(exp_q.size()), 64'(0));
        chk("left_hdrs", 64'(hdr_q.size()), 64'(0));
        chk("left_errs", 64'(exp_err), 64'(0));
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
